// File: rtl/fu_issue.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue
// Purpose  : Command-side controller for the fu: 8-entry RF, operand issue with
//            writeback forwarding, result/flag capture and retire reporting.
// Revision : 1.0 - initial release
// ============================================================================
module fu_issue #(
  parameter int OPSIZE = 5,
  parameter int DSIZE  = 16,
  parameter int RADDR  = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ld,
  input  logic [OPSIZE-1:0] cmd_op,
  input  logic [RADDR-1:0]  cmd_rd,
  input  logic [RADDR-1:0]  cmd_ra,
  input  logic [RADDR-1:0]  cmd_rb,
  input  logic [DSIZE-1:0]  cmd_imm,
  output logic [OPSIZE-1:0] fu_op,
  output logic [DSIZE-1:0]  fu_data_a,
  output logic [DSIZE-1:0]  fu_data_b,
  input  logic [DSIZE-1:0]  fu_f,
  input  logic              fu_n,
  input  logic              fu_c,
  input  logic              fu_v,
  input  logic              fu_z,
  output logic              res_valid,
  output logic [RADDR-1:0]  res_rd,
  output logic [DSIZE-1:0]  res_data,
  output logic [3:0]        status,
  output logic [15:0]       ret_cnt,
  input  logic [RADDR-1:0]  dbg_addr,
  output logic [DSIZE-1:0]  dbg_data
);

  localparam int c_NREG = 1 << RADDR;

  logic              r_ready;
  logic              r_pend_v;
  logic              r_pend_ld;
  logic [RADDR-1:0]  r_pend_rd;
  logic [DSIZE-1:0]  r_pend_imm;
  logic [DSIZE-1:0]  r_rf [c_NREG];
  logic              r_res_valid;
  logic [RADDR-1:0]  r_res_rd;
  logic [DSIZE-1:0]  r_res_data;
  logic [3:0]        r_status;
  logic [15:0]       r_ret_cnt;

  logic              w_accept;
  logic [DSIZE-1:0]  w_wb_data;
  logic [DSIZE-1:0]  w_opa;
  logic [DSIZE-1:0]  w_opb;

  assign w_accept  = cmd_valid & r_ready;
  assign w_wb_data = r_pend_ld ? r_pend_imm : fu_f;

  // Operand select: r0 reads zero, then the in-flight writeback, then the RF.
  always_comb begin
    w_opa = r_rf[cmd_ra];
    w_opb = r_rf[cmd_rb];
    if (r_pend_v && (r_pend_rd == cmd_ra)) w_opa = w_wb_data;
    if (r_pend_v && (r_pend_rd == cmd_rb)) w_opb = w_wb_data;
    if (cmd_ra == '0) w_opa = '0;
    if (cmd_rb == '0) w_opb = '0;
  end

  assign fu_op     = cmd_op;
  assign fu_data_a = w_opa;
  assign fu_data_b = w_opb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready    <= 1'b0;
      r_pend_v   <= 1'b0;
      r_pend_ld  <= 1'b0;
      r_pend_rd  <= '0;
      r_pend_imm <= '0;
    end else begin
      r_ready  <= 1'b1;
      r_pend_v <= w_accept;
      if (w_accept) begin
        r_pend_ld  <= cmd_ld;
        r_pend_rd  <= cmd_rd;
        r_pend_imm <= cmd_imm;
      end
    end
  end

  // r0 is never written so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < c_NREG; i++) r_rf[i] <= '0;
    end else if (r_pend_v && (r_pend_rd != '0)) begin
      r_rf[r_pend_rd] <= w_wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_rd    <= '0;
      r_res_data  <= '0;
      r_status    <= '0;
      r_ret_cnt   <= '0;
    end else begin
      r_res_valid <= r_pend_v;
      if (r_pend_v) begin
        r_res_rd   <= r_pend_rd;
        r_res_data <= w_wb_data;
        r_ret_cnt  <= r_ret_cnt + 16'd1;
        if (!r_pend_ld) r_status <= {fu_n, fu_c, fu_v, fu_z};
      end
    end
  end

  assign cmd_ready = r_ready;
  assign res_valid = r_res_valid;
  assign res_rd    = r_res_rd;
  assign res_data  = r_res_data;
  assign status    = r_status;
  assign ret_cnt   = r_ret_cnt;
  assign dbg_data  = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];

endmodule
`default_nettype wire

// File: tb/tb_fu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_issue
// Purpose  : Directed bench for fu_issue with a small add/sub fu model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_issue;

  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_ld;
  logic [4:0]  cmd_op, fu_op;
  logic [2:0]  cmd_rd, cmd_ra, cmd_rb, res_rd, dbg_addr;
  logic [15:0] cmd_imm, fu_data_a, fu_data_b, fu_f, res_data, ret_cnt, dbg_data;
  logic        fu_n, fu_c, fu_v, fu_z, res_valid;
  logic [3:0]  status;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fu_issue dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_imm(cmd_imm),
    .fu_op(fu_op), .fu_data_a(fu_data_a), .fu_data_b(fu_data_b),
    .fu_f(fu_f), .fu_n(fu_n), .fu_c(fu_c), .fu_v(fu_v), .fu_z(fu_z),
    .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data),
    .status(status), .ret_cnt(ret_cnt), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  // Registered fu model: add and subtract (C = carry / borrow).
  logic [16:0] m_sum, m_dif, m_res;
  logic        m_v;
  always_comb begin
    m_sum = {1'b0, fu_data_a} + {1'b0, fu_data_b};
    m_dif = {1'b0, fu_data_a} - {1'b0, fu_data_b};
    if (fu_op == OP_SUB) begin
      m_res = m_dif;
      m_v   = (fu_data_a[15] != fu_data_b[15]) && (m_dif[15] != fu_data_a[15]);
    end else begin
      m_res = m_sum;
      m_v   = (fu_data_a[15] == fu_data_b[15]) && (m_sum[15] != fu_data_a[15]);
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fu_f <= '0; fu_n <= 1'b0; fu_c <= 1'b0; fu_v <= 1'b0; fu_z <= 1'b0;
    end else begin
      fu_f <= m_res[15:0];
      fu_n <= m_res[15];
      fu_c <= m_res[16];
      fu_v <= m_v;
      fu_z <= (m_res[15:0] == 16'h0000);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic ld, input logic [4:0] op, input logic [2:0] rd,
                     input logic [2:0] ra, input logic [2:0] rb, input logic [15:0] imm);
    cmd_valid = 1'b1; cmd_ld = ld; cmd_op = op;
    cmd_rd = rd; cmd_ra = ra; cmd_rb = rb; cmd_imm = imm;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_ld = 1'b0; cmd_op = '0;
    cmd_rd = '0; cmd_ra = '0; cmd_rb = '0; cmd_imm = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    dbg_addr = '0;
    #12;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %b expected 0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_first_cycle: got %b expected 0", cmd_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rst_res_valid: got %b expected 0", res_valid); end
    checks++; if (res_rd !== 3'd0) begin errors++; $display("FAIL rst_res_rd: got %h expected 0", res_rd); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL rst_res_data: got %h expected 0000", res_data); end
    checks++; if (status !== 4'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", status); end
    checks++; if (ret_cnt !== 16'h0000) begin errors++; $display("FAIL rst_ret_cnt: got %h expected 0000", ret_cnt); end
    for (int a = 0; a < 8; a++) begin
      dbg_addr = a[2:0];
      #1;
      checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL rst_dbg r%0d: got %h expected 0000", a, dbg_data); end
    end
    step();
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready_high: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_load();
    cmd(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 16'hBEEF);
    step();
    idle();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ld_early_valid: got %b expected 0", res_valid); end
    step();
    dbg_addr = 3'd3;
    #1;
    checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL ld_res_valid: got %b expected 1", res_valid); end
    checks++; if (res_rd !== 3'd3) begin errors++; $display("FAIL ld_res_rd: got %h expected 3", res_rd); end
    checks++; if (res_data !== 16'hBEEF) begin errors++; $display("FAIL ld_res_data: got %h expected beef", res_data); end
    checks++; if (dbg_data !== 16'hBEEF) begin errors++; $display("FAIL ld_dbg_r3: got %h expected beef", dbg_data); end
    checks++; if (status !== 4'h0) begin errors++; $display("FAIL ld_status: got %h expected 0", status); end
    checks++; if (ret_cnt !== 16'd1) begin errors++; $display("FAIL ld_ret_cnt: got %h expected 0001", ret_cnt); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL ld_pulse_end: got %b expected 0", res_valid); end
  endtask

  task automatic test_forwarding();
    cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'h0005);
    step();
    cmd(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 16'h0003);
    step();
    cmd(1'b0, OP_ADD, 3'd4, 3'd1, 3'd2, 16'h0000);
    #1;
    checks++; if (fu_data_a !== 16'h0005) begin errors++; $display("FAIL fwd_a_rf: got %h expected 0005", fu_data_a); end
    checks++; if (fu_data_b !== 16'h0003) begin errors++; $display("FAIL fwd_b_imm: got %h expected 0003", fu_data_b); end
    checks++; if (fu_op !== OP_ADD) begin errors++; $display("FAIL fwd_op: got %h expected %h", fu_op, OP_ADD); end
    step();
    cmd(1'b0, OP_ADD, 3'd5, 3'd4, 3'd4, 16'h0000);
    #1;
    checks++; if (fu_data_a !== 16'h0008) begin errors++; $display("FAIL fwd_a_fu: got %h expected 0008", fu_data_a); end
    checks++; if (fu_data_b !== 16'h0008) begin errors++; $display("FAIL fwd_b_fu: got %h expected 0008", fu_data_b); end
    step();
    checks++; if (res_rd !== 3'd4 || res_data !== 16'h0008) begin errors++; $display("FAIL add_res: got r%0d=%h expected r4=0008", res_rd, res_data); end
    checks++; if (status !== 4'h0) begin errors++; $display("FAIL add_status: got %h expected 0", status); end
    cmd(1'b0, OP_SUB, 3'd6, 3'd2, 3'd1, 16'h0000);
    step();
    idle();
    checks++; if (res_rd !== 3'd5 || res_data !== 16'h0010) begin errors++; $display("FAIL chain_res: got r%0d=%h expected r5=0010", res_rd, res_data); end
    step();
    checks++; if (res_valid !== 1'b1 || res_rd !== 3'd6 || res_data !== 16'hFFFE) begin errors++; $display("FAIL sub_res: got v%b r%0d=%h expected v1 r6=fffe", res_valid, res_rd, res_data); end
    checks++; if (status !== 4'hC) begin errors++; $display("FAIL sub_status: got %h expected c", status); end
    checks++; if (ret_cnt !== 16'd6) begin errors++; $display("FAIL fwd_ret_cnt: got %h expected 0006", ret_cnt); end
  endtask

  task automatic test_r0_compare();
    cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'h1234);
    step();
    cmd(1'b1, OP_ADD, 3'd2, 3'd0, 3'd0, 16'h1234);
    step();
    cmd(1'b0, OP_SUB, 3'd0, 3'd1, 3'd2, 16'h0000);
    step();
    idle();
    step();
    dbg_addr = 3'd0;
    #1;
    checks++; if (res_valid !== 1'b1 || res_rd !== 3'd0) begin errors++; $display("FAIL cmp_res_rd: got v%b r%0d expected v1 r0", res_valid, res_rd); end
    checks++; if (res_data !== 16'h0000) begin errors++; $display("FAIL cmp_res_data: got %h expected 0000", res_data); end
    checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL cmp_r0: got %h expected 0000", dbg_data); end
    checks++; if (status !== 4'h1) begin errors++; $display("FAIL cmp_status: got %h expected 1", status); end
    checks++; if (ret_cnt !== 16'd9) begin errors++; $display("FAIL cmp_ret_cnt: got %h expected 0009", ret_cnt); end
    cmd(1'b1, OP_SUB, 3'd7, 3'd0, 3'd0, 16'h00AA);
    step();
    idle();
    step();
    dbg_addr = 3'd7;
    #1;
    checks++; if (status !== 4'h1) begin errors++; $display("FAIL ld_keeps_status: got %h expected 1", status); end
    checks++; if (dbg_data !== 16'h00AA) begin errors++; $display("FAIL ld_r7: got %h expected 00aa", dbg_data); end
  endtask

  task automatic test_reset_midflight();
    cmd(1'b1, OP_ADD, 3'd3, 3'd0, 3'd0, 16'h5555);
    step();
    idle();
    rst_n = 1'b0;
    dbg_addr = 3'd3;
    #1;
    checks++; if (res_valid !== 1'b0 || ret_cnt !== 16'd0) begin errors++; $display("FAIL mid_rst_out: got v%b cnt %h expected v0 cnt 0000", res_valid, ret_cnt); end
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", cmd_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL mid_no_retire: got %b expected 0", res_valid); end
    checks++; if (dbg_data !== 16'h0000) begin errors++; $display("FAIL mid_r3: got %h expected 0000", dbg_data); end
    step();
    checks++; if (res_valid !== 1'b0 || ret_cnt !== 16'd0) begin errors++; $display("FAIL mid_late: got v%b cnt %h expected v0 cnt 0000", res_valid, ret_cnt); end
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_ready_back: got %b expected 1", cmd_ready); end
  endtask

  task automatic test_back_to_back_wrap();
    int miss = 0;
    cmd(1'b1, OP_ADD, 3'd1, 3'd0, 3'd0, 16'h0000);
    for (int i = 0; i < 65536; i++) begin
      cmd_imm = i[15:0];
      step();
      if (i >= 1 && res_valid !== 1'b1) miss++;
    end
    idle();
    checks++; if (miss != 0) begin errors++; $display("FAIL wrap_stream_valid: got %0d gaps expected 0", miss); end
    checks++; if (ret_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_cnt_ffff: got %h expected ffff", ret_cnt); end
    step();
    dbg_addr = 3'd1;
    #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 16'hFFFF) begin errors++; $display("FAIL wrap_last: got v%b %h expected v1 ffff", res_valid, res_data); end
    checks++; if (ret_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_cnt_zero: got %h expected 0000", ret_cnt); end
    checks++; if (dbg_data !== 16'hFFFF) begin errors++; $display("FAIL wrap_r1: got %h expected ffff", dbg_data); end
    step();
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %b expected 0", res_valid); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_forwarding();
    test_r0_compare();
    test_reset_midflight();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fu_issue.md
# fu_issue

Command-side controller for the functional unit (`fu`). It owns an 8-entry register file, accepts one instruction per cycle over a valid/ready handshake, and drives the fu's `op`/`data_a`/`data_b`. It captures the registered result and N/C/V/Z flags one cycle later, then writes the result back and reports it on a result port. It sits between the instruction source (testbench or sequencer) and the fu, and is the producer side of the fu's operand/op interface.

## Interface
- OPSIZE, 5, width of fu op code (passed through unmodified)
- DSIZE, 16, datapath width
- RADDR, 3, register address width (2^RADDR registers; r0 hard-wired zero)
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  controller can accept a command
- cmd_ld  in  1  1 = load immediate, fu bypassed; 0 = fu operation
- cmd_op  in  OPSIZE  fu op code
- cmd_rd / cmd_ra / cmd_rb  in  RADDR each  destination / source A / source B
- cmd_imm  in  DSIZE  immediate for cmd_ld
- fu_op  out  OPSIZE  to fu `op`
- fu_data_a / fu_data_b  out  DSIZE each  to fu `data_a` / `data_b`
- fu_f  in  DSIZE  fu `F_o`
- fu_n / fu_c / fu_v / fu_z  in  1 each  fu flags
- res_valid  out  1  one-cycle pulse per retired command
- res_rd  out  RADDR  destination of retired command
- res_data  out  DSIZE  value written
- status  out  4  {N,C,V,Z} of last retired fu operation
- ret_cnt  out  16  retired command count
- dbg_addr  in  RADDR  debug read address
- dbg_data  out  DSIZE  combinational RF read; 0 for r0

## Operation
- Accept when cmd_valid && cmd_ready at a rising edge. cmd_ready is registered: 0 in reset and the first cycle after rst_n rises, 1 thereafter. No backpressure after that.
- Issue stage (cycle t, combinational):
  - fu_op = cmd_op.
  - fu_data_a/b = operand(cmd_ra)/operand(cmd_rb), driven unconditionally.
- operand(r):
  - 0 if r==0.
  - Otherwise the pending writeback data if a pending command targets r (forwarding).
  - Otherwise RF[r].
- Pending stage: on accept, register pend_v=1, pend_ld, pend_rd, pend_imm. Without an accept, pend_v=0.
- Writeback (edge ending cycle t+1, when pend_v):
  - wb_data = pend_ld ? pend_imm : fu_f.
  - RF[pend_rd] <= wb_data unless pend_rd==0. Write to r0 is discarded, but flags still update (compare idiom).
  - status <= {fu_n,fu_c,fu_v,fu_z} only when !pend_ld. Loads leave status unchanged.
  - res_valid<=1, res_rd<=pend_rd, res_data<=wb_data. res_data is reported even for r0.
  - ret_cnt<=ret_cnt+1, wrapping 0xFFFF->0x0000.
- With no pend_v: res_valid<=0; res_rd/res_data hold.
- Forwarding source while pend_v is wb_data (fu_f or pend_imm). This covers a back-to-back dependency at full rate with no stall.
- A dbg read of a register being written this cycle returns the old value.

## Timing
- Latency: command accepted at edge E0 → fu registers at E0 → fu_f valid cycle t+1 → RF/status/res regs update at E1 → res_valid high the cycle after E1 (2 cycles after accept).
- Throughput: 1 command/cycle. Consecutive writes to the same rd retire in order; the last one wins.
- Reset (async, any time, including mid-operation):
  - cmd_ready=0, pend_v=0 (in-flight command dropped).
  - All RF=0, status=0, res_valid=0, res_rd=0, res_data=0, ret_cnt=0.
- The fu is reset by the same rst_n. Its output is ignored until a pending command exists.

## Test plan
- Reset release: hold rst_n=0, then release → cmd_ready=0 for one cycle then 1. All outputs 0 and dbg_data=0 for every address.
- Load then read: ld r3=0xBEEF → res_valid pulse 2 cycles after accept with res_rd=3, res_data=0xBEEF. dbg r3=0xBEEF, status unchanged, ret_cnt=1.
- Forwarding: back-to-back ld r1=0x0005, ld r2=0x0003, then fu op ra=r1 rb=r2 in the next cycle → fu_data_a=0x0005, fu_data_b=0x0003 in the issue cycle. The result equals the fu output, and status equals the fu flags.
- r0 compare: fu op with rd=0 on equal operands 0x1234/0x1234 (subtract-type op) → r0 reads 0, res_rd=0, status Z=1, ret_cnt increments.
- Reset mid-flight: accept a command, assert rst_n low in the next cycle before E1 → no res_valid, target register stays 0, ret_cnt=0.
- Counter wrap: 65536 back-to-back loads → ret_cnt returns to 0x0000. res_valid is high every cycle during the stream.
